run_control: RTL and testbench

//  Front-panel run/step/breakpoint sequencer for the CPU core. Debounces the step button and

---
 rtl/run_control.sv | 204 ++++++++++++++++++++
 tb/tb_run_control.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control.sv
// run_control
//   Front-panel run/step/breakpoint sequencer for the CPU core. Sits between the
//   board pins and the core's clock-enable input.
//   The step button is synchronised and debounced. A single rising edge of the
//   debounced level yields a one-clock step pulse.
//   The breakpoint is latched from the switches on the first clock after reset.
//   A free-running mod-RUN_DIV counter paces every enable the core receives.
//
// Ports
//   i_clk                 system clock
//   i_resetn              asynchronous active-low reset
//   i_btnStep             raw step button (asynchronous, 1 = pressed)
//   i_swInstrNCycle       1 = step one instruction, 0 = step one CPU cycle
//   i_swStepNRun          1 = step mode, 0 = run mode
//   i_swEnableBreakpoint  1 = breakpoint compare active while running
//   i_switches[7:0]       breakpoint source, captured once after reset
//   i_pc[15:0]            core PC, meaningful when i_instrBoundary = 1
//   i_instrBoundary       next CPU cycle is the fetch cycle of an instruction
//   o_cpuClkEn            one-clock enable; the core advances one cycle
//   o_running             state is RUN
//   o_breakHit            state is BREAK
//   o_breakpoint[15:0]    latched breakpoint {8'h00, switches}
module run_control #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int RUN_DIV         = 4
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_btnStep,
    input  logic        i_swInstrNCycle,
    input  logic        i_swStepNRun,
    input  logic        i_swEnableBreakpoint,
    input  logic [7:0]  i_switches,
    input  logic [15:0] i_pc,
    input  logic        i_instrBoundary,
    output logic        o_cpuClkEn,
    output logic        o_running,
    output logic        o_breakHit,
    output logic [15:0] o_breakpoint
);

    localparam int TICK_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HALT,
        S_STEP_CYC,
        S_STEP_INS,
        S_RUN,
        S_BREAK
    } state_t;

    state_t              state;
    logic                bp_set;
    logic [15:0]         breakpoint;
    logic                btn_meta;
    logic                btn_sync;
    logic [DEB_W-1:0]    deb_cnt;
    logic                deb_level;
    logic                deb_level_q;
    logic                step_pulse;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                bp_match;
    logic                issued;
    logic                skip;
    logic                cpu_clk_en;

    // Breakpoint capture: one shot after each reset release.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            bp_set     <= 1'b0;
            breakpoint <= 16'h0000;
        end else if (!bp_set) begin
            breakpoint <= {8'h00, i_switches};
            bp_set     <= 1'b1;
        end
    end

    assign o_breakpoint = breakpoint;

    // Button: two-flop synchroniser, then the level only follows the synced
    // value once it has disagreed for DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            deb_level_q <= 1'b0;
        end else begin
            btn_meta    <= i_btnStep;
            btn_sync    <= btn_meta;
            deb_level_q <= deb_level;
            if (btn_sync != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= btn_sync;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign step_pulse = deb_level & ~deb_level_q;

    // Free-running tick divider, never gated by the state.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick     = (tick_cnt == TICK_LAST);
    assign bp_match = i_swEnableBreakpoint & i_instrBoundary & (i_pc == breakpoint);

    // The enable is decoded from the current state and the live core inputs,
    // so the core consumes it on the same edge at which the sequencer decides
    // what happens next; a registered enable would lag the boundary flag by
    // one clock and miscount instructions when RUN_DIV is 1.
    always_comb begin
        cpu_clk_en = 1'b0;
        case (state)
            S_STEP_CYC: cpu_clk_en = tick;
            S_STEP_INS: cpu_clk_en = tick & ~(issued & i_instrBoundary);
            S_RUN:      cpu_clk_en = tick & ~(bp_match & ~skip);
            default:    cpu_clk_en = 1'b0;
        endcase
    end

    assign o_cpuClkEn = cpu_clk_en;

    // Sequencer. Mode-switch checks come last in each state so they override
    // a same-clock tick decision; a step pulse arriving in a state that does
    // not consume it is simply dropped.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state  <= S_HALT;
            issued <= 1'b0;
            skip   <= 1'b0;
        end else begin
            case (state)
                S_HALT: begin
                    if (!i_swStepNRun) begin
                        state <= S_RUN;
                        skip  <= 1'b0;
                    end else if (step_pulse) begin
                        if (i_swInstrNCycle) begin
                            state  <= S_STEP_INS;
                            issued <= 1'b0;
                        end else begin
                            state <= S_STEP_CYC;
                        end
                    end
                end
                S_STEP_CYC: begin
                    if (tick) state <= S_HALT;
                end
                S_STEP_INS: begin
                    // Stop at the first boundary seen after at least one enable,
                    // leaving the core at the fetch of the next instruction.
                    if (tick) begin
                        if (issued && i_instrBoundary) state  <= S_HALT;
                        else                           issued <= 1'b1;
                    end
                    if (!i_swStepNRun) begin
                        state <= S_RUN;
                        skip  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (bp_match && !skip) state <= S_BREAK;
                        else                   skip  <= 1'b0;
                    end
                    if (i_swStepNRun) state <= S_HALT;
                end
                S_BREAK: begin
                    if (i_swStepNRun) begin
                        state <= S_HALT;
                    end else if (step_pulse) begin
                        // skip lets the instruction sitting at the breakpoint run once.
                        state <= S_RUN;
                        skip  <= 1'b1;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    assign o_running  = (state == S_RUN);
    assign o_breakHit = (state == S_BREAK);

endmodule

// File: tb/tb_run_control.sv
// tb_run_control
//   Directed bench for run_control with a short debounce (8 clocks) and RUN_DIV = 4.
//   A small core model counts consumed enables; it supplies a PC of 0x40 + count
//   and/or an instruction boundary every 5 CPU cycles when selected.
module tb_run_control;

    localparam int DB = 8;
    localparam int RD = 4;

    logic        clk;
    logic        rst_n;
    logic        btn;
    logic        instr_n_cycle;
    logic        step_n_run;
    logic        en_bp;
    logic [7:0]  switches;
    logic [15:0] pc_in;
    logic        bnd_in;
    logic        cpu_en;
    logic        running;
    logic        break_hit;
    logic [15:0] bp_out;

    logic        pc_sel;
    logic [15:0] pc_man;
    logic        bnd_mode;
    logic        bnd_man;
    logic        core_clr;
    int          core_cyc;
    logic        en_s;
    int          en_count;
    int          align_err;
    int          tcnt;
    logic        tick_m;

    int tests;
    int fails;

    run_control #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
        .i_clk                (clk),
        .i_resetn             (rst_n),
        .i_btnStep            (btn),
        .i_swInstrNCycle      (instr_n_cycle),
        .i_swStepNRun         (step_n_run),
        .i_swEnableBreakpoint (en_bp),
        .i_switches           (switches),
        .i_pc                 (pc_in),
        .i_instrBoundary      (bnd_in),
        .o_cpuClkEn           (cpu_en),
        .o_running            (running),
        .o_breakHit           (break_hit),
        .o_breakpoint         (bp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pc_in  = pc_sel ? (16'h0040 + core_cyc[15:0]) : pc_man;
    assign bnd_in = bnd_mode ? ((core_cyc % 5) == 0) : bnd_man;

    // Reference tick: mod-RD count of clocks since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           tcnt <= 0;
        else if (tcnt == RD-1) tcnt <= 0;
        else                  tcnt <= tcnt + 1;
    end
    assign tick_m = (tcnt == RD-1);

    // Enable monitor, sampled mid-cycle after inputs have settled.
    initial begin
        en_count  = 0;
        align_err = 0;
        en_s      = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            en_s = cpu_en;
            if (cpu_en === 1'b1) begin
                en_count++;
                if (!tick_m) align_err++;
            end
        end
    end

    // Core model: advances one cycle per consumed enable.
    always @(posedge clk) begin
        if (core_clr)  core_cyc <= 0;
        else if (en_s) core_cyc <= core_cyc + 1;
    end

    typedef struct {
        logic [7:0]  sw;
        logic [15:0] exp_bp;
    } latch_vec_t;

    typedef struct {
        logic        en_bp;
        logic        bnd;
        logic [15:0] pc;
        logic        exp_en;
        logic        exp_break;
    } run_vec_t;

    latch_vec_t lv[4];
    run_vec_t   rv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_m && n < 2*RD);
        if (!tick_m) check("tick_wait", 32'd0, 32'd1);
    endtask

    task automatic clear_core();
        core_clr = 1'b1;
        @(negedge clk);
        core_clr = 1'b0;
    endtask

    task automatic press(input int hold, input int after);
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (after) @(negedge clk);
    endtask

    initial begin
        int c0;
        int n;
        tests = 0;
        fails = 0;

        lv[0] = '{8'hA5, 16'h00A5};
        lv[1] = '{8'h00, 16'h0000};
        lv[2] = '{8'hFF, 16'h00FF};
        lv[3] = '{8'h42, 16'h0042};

        rv[0] = '{1'b1, 1'b1, 16'h0042, 1'b0, 1'b1};
        rv[1] = '{1'b0, 1'b1, 16'h0042, 1'b1, 1'b0};
        rv[2] = '{1'b1, 1'b0, 16'h0042, 1'b1, 1'b0};
        rv[3] = '{1'b1, 1'b1, 16'h0043, 1'b1, 1'b0};
        rv[4] = '{1'b1, 1'b1, 16'h1042, 1'b1, 1'b0};
        rv[5] = '{1'b1, 1'b1, 16'h0042, 1'b0, 1'b1};

        rst_n         = 1'b0;
        btn           = 1'b0;
        instr_n_cycle = 1'b0;
        step_n_run    = 1'b1;
        en_bp         = 1'b0;
        switches      = 8'h00;
        pc_sel        = 1'b0;
        pc_man        = 16'h0000;
        bnd_mode      = 1'b0;
        bnd_man       = 1'b0;
        core_clr      = 1'b1;

        repeat (3) @(negedge clk);
        core_clr = 1'b0;
        #1;
        check("reset_en",      {31'd0, cpu_en},    32'd0);
        check("reset_running", {31'd0, running},   32'd0);
        check("reset_break",   {31'd0, break_hit}, 32'd0);
        check("reset_bp",      {16'd0, bp_out},    32'd0);

        // Breakpoint latch: captured one clock after release, then held.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n    = 1'b0;
            switches = lv[i].sw;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("bp_latch", {16'd0, bp_out}, {16'd0, lv[i].exp_bp});
            switches = ~lv[i].sw;
            repeat (3) @(negedge clk);
            check("bp_hold", {16'd0, bp_out}, {16'd0, lv[i].exp_bp});
        end
        check("step_idle_no_en", en_count, 32'd0);

        // Bouncy press, then a solid hold: exactly one cycle step.
        c0 = en_count;
        btn = 1'b1; repeat (3) @(negedge clk);
        btn = 1'b0; repeat (2) @(negedge clk);
        btn = 1'b1; repeat (4) @(negedge clk);
        btn = 1'b0; repeat (1) @(negedge clk);
        press(20, 25);
        check("step_cyc_enables", en_count - c0, 32'd1);
        check("step_cyc_halt", {31'd0, running}, 32'd0);

        // Instruction step with 5-cycle instructions: two presses, five enables each.
        instr_n_cycle = 1'b1;
        bnd_mode      = 1'b1;
        clear_core();
        c0 = en_count;
        press(15, 40);
        check("step_ins_enables1", en_count - c0, 32'd5);
        check("step_ins_core1", core_cyc, 32'd5);
        c0 = en_count;
        press(15, 40);
        check("step_ins_enables2", en_count - c0, 32'd5);
        check("step_ins_core2", core_cyc, 32'd10);
        check("step_ins_halt", {30'd0, running, break_hit}, 32'd0);

        // Run mode, breakpoint 0x42: one vector per tick.
        bnd_mode   = 1'b0;
        bnd_man    = 1'b0;
        step_n_run = 1'b0;
        repeat (2) @(negedge clk);
        check("run_entered", {31'd0, running}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            en_bp   = rv[i].en_bp;
            bnd_man = rv[i].bnd;
            pc_man  = rv[i].pc;
            #1;
            check("run_vec_en", {31'd0, cpu_en}, {31'd0, rv[i].exp_en});
            @(negedge clk);
            en_bp   = 1'b0;
            bnd_man = 1'b0;
            check("run_vec_break", {31'd0, break_hit}, {31'd0, rv[i].exp_break});
            check("run_vec_running", {31'd0, running}, {31'd0, ~rv[i].exp_break});
            if (rv[i].exp_break) begin
                step_n_run = 1'b1;
                @(negedge clk);
                step_n_run = 1'b0;
                repeat (2) @(negedge clk);
            end
        end

        // Free run with compare disabled at a matching PC: one enable every 4 clocks.
        en_bp   = 1'b0;
        bnd_man = 1'b1;
        pc_man  = 16'h0042;
        @(negedge clk);
        #3;
        c0 = en_count;
        repeat (40) @(negedge clk);
        #3;
        check("run_spacing", en_count - c0, 32'd10);
        check("run_no_break", {31'd0, break_hit}, 32'd0);

        // Break and resume with a one-cycle-per-instruction core at PC 0x40+n.
        step_n_run = 1'b1;
        repeat (2) @(negedge clk);
        clear_core();
        pc_sel     = 1'b1;
        bnd_man    = 1'b1;
        en_bp      = 1'b1;
        step_n_run = 1'b0;
        n = 0;
        while (!break_hit && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("break_reached", {31'd0, break_hit}, 32'd1);
        check("break_core_pc", core_cyc, 32'd2);
        check("break_not_running", {31'd0, running}, 32'd0);
        c0 = en_count;
        repeat (12) @(negedge clk);
        check("break_no_en", en_count - c0, 32'd0);
        btn = 1'b1;
        n = 0;
        while (!running && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("resume_running", {31'd0, running}, 32'd1);
        btn = 1'b0;
        repeat (30) @(negedge clk);
        check("resume_progress", {31'd0, (core_cyc >= 5)}, 32'd1);
        check("resume_no_break", {31'd0, break_hit}, 32'd0);

        // Reset in the middle of an instruction step.
        step_n_run = 1'b1;
        en_bp      = 1'b0;
        pc_sel     = 1'b0;
        repeat (2) @(negedge clk);
        bnd_mode      = 1'b1;
        instr_n_cycle = 1'b1;
        clear_core();
        switches = 8'h99;
        c0  = en_count;
        btn = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (en_count == c0 && n < 40);
        check("sins_started", en_count - c0, 32'd1);
        btn = 1'b0;
        wait_tick();
        #1;
        check("sins_mid_en", {31'd0, cpu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_en", {31'd0, cpu_en}, 32'd0);
        check("rst_mid_state", {30'd0, running, break_hit}, 32'd0);
        check("rst_mid_bp", {16'd0, bp_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_relatch_bp", {16'd0, bp_out}, 32'h0099);
        #3;
        c0 = en_count;
        repeat (30) @(negedge clk);
        check("rst_halt_no_en", en_count - c0, 32'd0);

        check("tick_align", align_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
